// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one word-addressed bus transaction per load/store,
// builds byte-lane masks/data, extends load data, and reports misaligned/illegal/timeout faults.
//
// state | meaning
// IDLE  | waiting for a memory instruction; request fields latched on accept
// REQ   | bus request asserted, waiting for grant
// WAIT  | load granted, waiting for read data
// DONE  | one-cycle completion pulse with exception status
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_exc,
    output logic [1:0]  o_exc_cause,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [3:0]  o_mem_wmask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        is_load_q;
    logic        wen_q;
    logic [3:0]  wmask_q;
    logic [31:0] wdata_q;
    logic [31:0] cnt_q;
    logic        exc_q;
    logic [1:0]  cause_q;
    logic [31:0] load_data_q;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic        tmo_hit;
    logic        tmo_fire;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Request decode from the live inputs; only used on the accept cycle.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        wmask_d    = 4'b0000;
        wdata_d    = 32'h0;
        if (i_is_load == i_is_store) begin
            illegal = 1'b1;
        end else if (i_is_load && (i_funct3 == 3'b011 || i_funct3 == 3'b110 ||
                                   i_funct3 == 3'b111)) begin
            illegal = 1'b1;
        end else if (i_is_store && i_funct3[2]) begin
            illegal = 1'b1;
        end
        if (i_funct3[1:0] == 2'b01 && i_addr[0]) begin
            misaligned = 1'b1;
        end else if (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00) begin
            misaligned = 1'b1;
        end
        if (i_is_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    wmask_d = 4'b0001 << i_addr[1:0];
                    wdata_d = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                    wmask_d = i_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{i_store_data[15:0]}};
                end
                default: begin
                    wmask_d = 4'b1111;
                    wdata_d = i_store_data;
                end
            endcase
        end
    end

    always_comb begin
        byte_sel = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = i_mem_rdata;
        endcase
    end

    // The counter is compared before it increments, so the timeout fires on the
    // TIMEOUT_CYCLES-th REQ/WAIT cycle without progress.
    assign tmo_hit = (TIMEOUT_LIM != 32'd0) && ((cnt_q + 32'd1) >= TIMEOUT_LIM);

    always_comb begin
        state_d  = state_q;
        tmo_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = (illegal || misaligned) ? DONE : REQ;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    state_d = is_load_q ? WAIT : DONE;
                end else if (tmo_hit) begin
                    state_d  = DONE;
                    tmo_fire = 1'b1;
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d  = DONE;
                    tmo_fire = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            funct3_q    <= 3'b000;
            is_load_q   <= 1'b0;
            wen_q       <= 1'b0;
            wmask_q     <= 4'b0000;
            wdata_q     <= 32'h0;
            cnt_q       <= 32'h0;
            exc_q       <= 1'b0;
            cause_q     <= 2'b00;
            load_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        addr_q    <= i_addr;
                        funct3_q  <= i_funct3;
                        is_load_q <= i_is_load;
                        wen_q     <= i_is_store;
                        wmask_q   <= wmask_d;
                        wdata_q   <= wdata_d;
                        cnt_q     <= 32'h0;
                        exc_q     <= illegal | misaligned;
                        cause_q   <= illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
                    end
                end
                REQ, WAIT: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (tmo_fire) begin
                        exc_q   <= 1'b1;
                        cause_q <= 2'b11;
                    end
                    if (state_q == WAIT && i_mem_rvalid) begin
                        load_data_q <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_done      = (state_q == DONE);
    assign o_busy      = i_valid & ~o_done;
    assign o_exc       = o_done & exc_q;
    assign o_exc_cause = o_done ? cause_q : 2'b00;
    assign o_load_data = load_data_q;
    assign o_mem_req   = (state_q == REQ);
    assign o_mem_addr  = {addr_q[31:2], 2'b00};
    assign o_mem_wen   = wen_q;
    assign o_mem_wmask = wmask_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: completion status, latency and load data are
// queued when an access is driven and compared when o_done fires.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_is_load;
    logic        i_is_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_load_data;
    logic        o_exc;
    logic [1:0]  o_exc_cause;
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [3:0]  o_mem_wmask;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_ld = 32'h0;

    typedef struct {
        int          lat;
        logic        exc;
        logic [1:0]  cause;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_is_load(i_is_load),
        .i_is_store(i_is_store), .i_funct3(i_funct3), .i_addr(i_addr),
        .i_store_data(i_store_data), .o_busy(o_busy), .o_done(o_done),
        .o_load_data(o_load_data), .o_exc(o_exc), .o_exc_cause(o_exc_cause),
        .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_addr(o_mem_addr),
        .o_mem_wen(o_mem_wen), .o_mem_wmask(o_mem_wmask), .o_mem_wdata(o_mem_wdata),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic do_access(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input int gnt_delay, input logic [31:0] rdata,
                             input logic exp_req, input logic [31:0] exp_maddr,
                             input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                             input int exp_lat, input logic exp_exc,
                             input logic [1:0] exp_cause, input logic [31:0] exp_ld,
                             input string name);
        exp_t e;
        int   n;
        int   req_seen;
        bit   give_rv;
        bit   done_seen;
        e.lat   = exp_lat;
        e.exc   = exp_exc;
        e.cause = exp_cause;
        e.data  = (ld && !st && !exp_exc) ? exp_ld : last_ld;
        sb_q.push_back(e);
        if (ld && !st && !exp_exc) last_ld = exp_ld;
        req_seen  = 0;
        give_rv   = 1'b0;
        done_seen = 1'b0;
        @(negedge i_clk);
        i_valid = 1'b1; i_is_load = ld; i_is_store = st; i_funct3 = f3;
        i_addr = addr; i_store_data = sdata;
        @(posedge i_clk);
        n = 1;
        while (!done_seen && n <= 40) begin
            @(negedge i_clk);
            i_mem_gnt = 1'b0;
            i_mem_rvalid = 1'b0;
            checks++;
            if (o_busy !== (i_valid & ~o_done)) begin
                failures++;
                $display("FAIL %s busy: got %b want %b", name, o_busy, i_valid & ~o_done);
            end
            if (o_mem_req) begin
                checks++;
                if (!exp_req) begin
                    failures++;
                    $display("FAIL %s unexpected_req: got req=1 want 0", name);
                end else if (o_mem_addr !== exp_maddr || o_mem_wen !== st ||
                             o_mem_wmask !== exp_mask || (st && o_mem_wdata !== exp_wdata)) begin
                    failures++;
                    $display("FAIL %s req_fields: got addr=%h wen=%b mask=%b wdata=%h want addr=%h wen=%b mask=%b wdata=%h",
                             name, o_mem_addr, o_mem_wen, o_mem_wmask, o_mem_wdata,
                             exp_maddr, st, exp_mask, exp_wdata);
                end
                if (req_seen == gnt_delay) begin
                    i_mem_gnt = 1'b1;
                    give_rv = ld;
                end
                req_seen++;
            end else if (give_rv) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata = rdata;
                give_rv = 1'b0;
            end
            if (o_done) begin
                e = sb_q.pop_front();
                checks++;
                if (n != e.lat || o_exc !== e.exc || o_exc_cause !== e.cause ||
                    o_load_data !== e.data) begin
                    failures++;
                    $display("FAIL %s completion: got lat=%0d exc=%b cause=%b data=%h want lat=%0d exc=%b cause=%b data=%h",
                             name, n, o_exc, o_exc_cause, o_load_data, e.lat, e.exc, e.cause, e.data);
                end
                done_seen = 1'b1;
                i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
            end else begin
                @(posedge i_clk);
                n++;
            end
        end
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL %s no_done: got none within 40 cycles want lat=%0d", name, exp_lat);
            void'(sb_q.pop_front());
            i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        i_funct3 = 3'b000; i_addr = 32'h0; i_store_data = 32'h0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if ({o_busy, o_done, o_exc, o_exc_cause, o_mem_req, o_mem_wen, o_mem_wmask} !== 10'b0 ||
            o_load_data !== 32'h0 || o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: got done=%b exc=%b req=%b data=%h addr=%h want all zero",
                     o_done, o_exc, o_mem_req, o_load_data, o_mem_addr);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_stores();
        do_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1, 32'h100, 4'b1111,
                  32'hDEADBEEF, 2, 0, 2'b00, 32'h0, "sw");
        do_access(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 32'h0, 1, 32'h200, 4'b1000,
                  32'hA5A5A5A5, 2, 0, 2'b00, 32'h0, "sb_lane3");
        do_access(0, 1, 3'b000, 32'h200, 32'h12345677, 0, 32'h0, 1, 32'h200, 4'b0001,
                  32'h77777777, 2, 0, 2'b00, 32'h0, "sb_lane0");
        do_access(0, 1, 3'b001, 32'h202, 32'h00001234, 0, 32'h0, 1, 32'h200, 4'b1100,
                  32'h12341234, 2, 0, 2'b00, 32'h0, "sh_upper");
        do_access(0, 1, 3'b001, 32'h200, 32'hFFFFBEEF, 0, 32'h0, 1, 32'h200, 4'b0011,
                  32'hBEEFBEEF, 2, 0, 2'b00, 32'h0, "sh_lower");
    endtask

    task automatic test_loads();
        do_access(1, 0, 3'b000, 32'h301, 32'h0, 0, 32'h0000F000, 1, 32'h300, 4'b0000,
                  32'h0, 3, 0, 2'b00, 32'hFFFFFFF0, "lb");
        do_access(1, 0, 3'b100, 32'h301, 32'h0, 0, 32'h0000F000, 1, 32'h300, 4'b0000,
                  32'h0, 3, 0, 2'b00, 32'h000000F0, "lbu");
        do_access(1, 0, 3'b001, 32'h302, 32'h0, 0, 32'h80010000, 1, 32'h300, 4'b0000,
                  32'h0, 3, 0, 2'b00, 32'hFFFF8001, "lh");
        do_access(1, 0, 3'b101, 32'h300, 32'h0, 0, 32'h80017FFE, 1, 32'h300, 4'b0000,
                  32'h0, 3, 0, 2'b00, 32'h00007FFE, "lhu");
        do_access(1, 0, 3'b010, 32'h308, 32'h0, 0, 32'h13579BDF, 1, 32'h308, 4'b0000,
                  32'h0, 3, 0, 2'b00, 32'h13579BDF, "lw");
    endtask

    task automatic test_delayed_gnt();
        do_access(1, 0, 3'b010, 32'h104, 32'h0, 3, 32'hCAFEF00D, 1, 32'h104, 4'b0000,
                  32'h0, 6, 0, 2'b00, 32'hCAFEF00D, "lw_gnt_delay3");
        do_access(0, 1, 3'b010, 32'h108, 32'h01020304, 2, 32'h0, 1, 32'h108, 4'b1111,
                  32'h01020304, 4, 0, 2'b00, 32'h0, "sw_gnt_delay2");
    endtask

    task automatic test_exceptions();
        do_access(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0,
                  1, 1, 2'b01, 32'h0, "lw_misaligned");
        do_access(0, 1, 3'b001, 32'h301, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0,
                  1, 1, 2'b01, 32'h0, "sh_misaligned");
        do_access(1, 0, 3'b110, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0,
                  1, 1, 2'b10, 32'h0, "load_f3_110");
        do_access(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0,
                  1, 1, 2'b10, 32'h0, "load_and_store");
        do_access(0, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0,
                  1, 1, 2'b10, 32'h0, "neither");
        do_access(0, 1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0,
                  1, 1, 2'b10, 32'h0, "store_f3_100");
        do_access(1, 0, 3'b011, 32'h101, 32'h0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0,
                  1, 1, 2'b10, 32'h0, "illegal_over_misaligned");
    endtask

    task automatic test_timeout();
        do_access(1, 0, 3'b010, 32'h400, 32'h0, 1000, 32'h0, 1, 32'h400, 4'b0000,
                  32'h0, 5, 1, 2'b11, 32'h0, "timeout");
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b0 || o_load_data !== last_ld) begin
            failures++;
            $display("FAIL timeout_after: got req=%b data=%h want req=0 data=%h",
                     o_mem_req, o_load_data, last_ld);
        end
    endtask

    task automatic test_back_to_back();
        do_access(0, 1, 3'b000, 32'h501, 32'h0000003C, 0, 32'h0, 1, 32'h500, 4'b0010,
                  32'h3C3C3C3C, 2, 0, 2'b00, 32'h0, "b2b_sb");
        do_access(1, 0, 3'b000, 32'h502, 32'h0, 0, 32'h00800000, 1, 32'h500, 4'b0000,
                  32'h0, 3, 0, 2'b00, 32'hFFFFFF80, "b2b_lb");
    endtask

    task automatic test_reset_mid_access();
        @(negedge i_clk);
        i_valid = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010;
        i_addr = 32'h600;
        @(posedge i_clk);
        @(negedge i_clk);
        i_mem_gnt = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_mem_gnt = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if ({o_done, o_exc, o_exc_cause, o_mem_req, o_mem_wen, o_mem_wmask} !== 9'b0 ||
            o_load_data !== 32'h0 || o_mem_addr !== 32'h0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_wait: got done=%b req=%b data=%h addr=%h busy=%b want zeros busy=1",
                     o_done, o_mem_req, o_load_data, o_mem_addr, o_busy);
        end
        i_rst = 1'b0; i_valid = 1'b0; i_is_load = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
        @(posedge i_clk);
        @(negedge i_clk);
        i_mem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_load_data !== 32'h0) begin
                failures++;
                $display("FAIL late_rvalid: got done=%b busy=%b data=%h want 0 0 00000000",
                         o_done, o_busy, o_load_data);
            end
            @(negedge i_clk);
        end
        last_ld = 32'h0;
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_delayed_gnt();
        test_exceptions();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage directly downstream of the ALU; it takes the ALU result as the effective address for loads and stores.
- Drives a request/grant/response word-addressed data bus.
- Builds byte-lane write masks and replicated write data; extracts and sign/zero-extends load data.
- Detects misaligned, illegal and timed-out accesses.
- Stalls the core with a busy signal until the access completes.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in REQ+WAIT before a bus-timeout exception; 0 disables timeout.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  memory instruction present; core holds all request inputs stable until o_done
i_is_load  input  1  load instruction
i_is_store  input  1  store instruction
i_funct3  input  3  RV32I width/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
i_addr  input  32  effective address (ALU o_result)
i_store_data  input  32  rs2 value
o_busy  output  1  stall request to core
o_done  output  1  one-cycle completion pulse
o_load_data  output  32  extended load result, valid with o_done
o_exc  output  1  exception, valid with o_done
o_exc_cause  output  2  01 misaligned, 10 illegal, 11 bus timeout
o_mem_req  output  1  bus request
i_mem_gnt  input  1  bus accepted request this cycle
o_mem_addr  output  32  word address {addr[31:2],2'b00}
o_mem_wen  output  1  write request
o_mem_wmask  output  4  byte-lane write enables
o_mem_wdata  output  32  lane-replicated write data
i_mem_rvalid  input  1  read data valid
i_mem_rdata  input  32  read word

Behaviour:
- Reset: state IDLE; all outputs 0, including o_load_data and counter. Reset mid-access abandons it; o_mem_req is low the cycle after the reset edge and no o_done is issued.
- States: IDLE, REQ, WAIT, DONE.
- o_busy = i_valid & ~o_done (combinational).
- IDLE, i_valid=1: latch addr, funct3, store data and load/store flag. Then check in priority order:
  - Illegal: both or neither of load/store; load funct3 in {011,110,111}; store funct3[2]=1. Go to DONE with cause 10.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Go to DONE with cause 01.
  - Otherwise go to REQ; clear the timeout counter.
- REQ:
  - o_mem_req=1 with registered addr/wen/wmask/wdata, held stable until i_mem_gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - i_mem_rvalid in REQ is ignored.
- WAIT: on i_mem_rvalid, register the extracted data into o_load_data, then go to DONE.
- Timeout: the counter increments on every REQ/WAIT cycle. If it reaches TIMEOUT_CYCLES (nonzero) with no progress, go to DONE with cause 11 and drop o_mem_req.
- DONE: o_done=1 for exactly one cycle, with o_exc/o_exc_cause. Next state is IDLE. o_exc=0 on success.
- o_load_data changes only on successful load completion; it holds its value otherwise.
- Minimum latencies, counting the accept edge as edge 0:
  - Store: gnt in the first REQ cycle gives o_done 2 cycles after accept.
  - Load: rvalid the cycle after gnt gives o_done 3 cycles after accept.
  - Exception with no bus access: o_done 1 cycle after accept.
- Store lanes (lane = addr[1:0]):
  - sb: wmask=1<<lane; wdata={4{byte}}.
  - sh: wmask = addr[1] ? 1100 : 0011; wdata={2{half}}.
  - sw: wmask=1111; wdata=rs2.
- Loads: o_mem_wen=0, wmask=0000. Select the byte/half by addr[1:0]. Sign-extend for 000/001; zero-extend for 100/101.
- A new request is accepted only in IDLE; i_valid during REQ/WAIT/DONE is not re-sampled.

Test Plan:
- sw addr 0x100, data 0xDEADBEEF, gnt in first REQ cycle -> o_mem_addr=0x100, wmask=1111, wdata=0xDEADBEEF, wen=1; o_done 2 cycles after accept, o_exc=0.
- sb addr 0x203, data 0x000000A5 -> addr 0x200, wmask=1000, wdata=0xA5A5A5A5. sh addr 0x202, data 0x1234 -> wmask=1100, wdata=0x12341234.
- lb addr 0x301, rdata 0x0000F000 -> 0xFFFFFFF0. lbu same -> 0x000000F0. lh addr 0x302, rdata 0x80010000 -> 0xFFFF8001. Gnt delayed 3 cycles -> o_done delayed 3 cycles, req held stable.
- lw addr 0x102 -> no o_mem_req; o_done 1 cycle after accept, o_exc=1, cause 01. Load funct3 110 -> cause 10. Load and store both set -> cause 10.
- TIMEOUT_CYCLES=4, gnt never asserted -> o_done, o_exc=1, cause 11, o_mem_req low afterwards, o_load_data unchanged.
- i_rst asserted while in WAIT -> next cycle state IDLE, all outputs 0, late rvalid ignored; o_busy high only while i_valid is held and o_done is low.
